// File: rtl/door_lock_pkg.sv
// Shared definitions for the door-lock datapath: keypad codes, FSM encoding and LCD message codes.
package door_lock_pkg;

  localparam logic [3:0] KEY_CLR       = 4'hE;
  localparam logic [3:0] KEY_ENT       = 4'hF;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [2:0] NUM_DIGITS    = 3'd4;
  localparam logic [2:0] FAILS_SAT     = 3'd7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEntry   = 2'd1,
    StCheck   = 2'd2,
    StLockout = 2'd3
  } state_e;

  // Message codes understood by the LCD stage.
  typedef enum logic [2:0] {
    MsgBlank    = 3'd0,
    MsgEnterPin = 3'd1,
    MsgOpen     = 3'd2,
    MsgDenied   = 3'd3,
    MsgLocked   = 3'd4
  } msg_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Idle-cycle counter: pulses expired when TIMEOUT_CYC running cycles pass without a reload.
module inactivity_timer #(
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A reload in the same cycle means there was activity, so no expiry.
  assign expired = run && !reload && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (reload || expired) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pin_entry_checker.sv
// Collects keypad digits into a 4-digit BCD buffer, checks it on ENTER and tracks failed
// attempts, raising lockout after MAX_FAILS consecutive failures.
module pin_entry_checker
  import door_lock_pkg::*;
#(
  parameter logic [15:0] CODE        = 16'h4693,
  parameter int unsigned MAX_FAILS   = 2,
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        clear_lock,
  output logic        match,
  output logic        fail,
  output logic        lockout,
  output logic [2:0]  digit_count,
  output logic [15:0] entry
);

  state_e      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  fails_q, fails_d;
  logic        match_q, match_d;
  logic        fail_q, fail_d;

  logic        key_accept;
  logic        timer_run;
  logic        timer_reload;
  logic        timer_expired;
  logic        code_ok;
  logic [2:0]  fails_inc;
  logic        go_lockout;

  assign timer_run    = (state_q == StEntry) && (count_q != 3'd0);
  assign timer_reload = (state_q != StEntry) || key_accept;

  inactivity_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (timer_run),
    .reload  (timer_reload),
    .expired (timer_expired)
  );

  assign code_ok    = (count_q == NUM_DIGITS) && (entry_q == CODE);
  assign fails_inc  = (fails_q == FAILS_SAT) ? FAILS_SAT : fails_q + 3'd1;
  assign go_lockout = (fails_inc >= 3'(MAX_FAILS));

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    fails_d    = fails_q;
    match_d    = 1'b0;
    fail_d     = 1'b0;
    key_accept = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StEntry;
          entry_d = '0;
          count_d = '0;
        end
      end

      StEntry: begin
        // Abort has priority over any key arriving in the same cycle.
        if (!enable) begin
          state_d = StIdle;
          entry_d = '0;
          count_d = '0;
        end else if (key_valid && (key_code == KEY_ENT)) begin
          key_accept = 1'b1;
          state_d    = StCheck;
        end else if (key_valid && (key_code == KEY_CLR)) begin
          key_accept = 1'b1;
          entry_d    = '0;
          count_d    = '0;
        end else if (key_valid && is_digit(key_code) && (count_q < NUM_DIGITS)) begin
          key_accept = 1'b1;
          entry_d    = {entry_q[11:0], key_code};
          count_d    = count_q + 3'd1;
        end else if (timer_expired) begin
          entry_d = '0;
          count_d = '0;
        end
      end

      StCheck: begin
        entry_d = '0;
        count_d = '0;
        if (code_ok) begin
          match_d = 1'b1;
          fails_d = '0;
          state_d = enable ? StEntry : StIdle;
        end else begin
          fail_d  = 1'b1;
          fails_d = fails_inc;
          if (go_lockout) begin
            state_d = StLockout;
          end else begin
            state_d = enable ? StEntry : StIdle;
          end
        end
      end

      StLockout: begin
        if (clear_lock) begin
          fails_d = '0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      entry_q <= '0;
      count_q <= '0;
      fails_q <= '0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      fails_q <= fails_d;
      match_q <= match_d;
      fail_q  <= fail_d;
    end
  end

  assign match       = match_q;
  assign fail        = fail_q;
  assign lockout     = (state_q == StLockout);
  assign digit_count = count_q;
  assign entry       = entry_q;

endmodule

// File: tb/tb_pin_entry_checker.sv
// Directed bench for pin_entry_checker: entry, match/fail, lockout, clear, timeout and abort.
module tb_pin_entry_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        clear_lock = 1'b0;
  logic        match;
  logic        fail;
  logic        lockout;
  logic [2:0]  digit_count;
  logic [15:0] entry;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic fail_seen;

  pin_entry_checker #(
    .CODE        (16'h4693),
    .MAX_FAILS   (2),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .clear_lock  (clear_lock),
    .match       (match),
    .fail        (fail),
    .lockout     (lockout),
    .digit_count (digit_count),
    .entry       (entry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one key strobe; returns at the negedge after the sampling edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_entry", 32'(entry), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_match", 32'(match), 32'h0);
    chk("rst_fail", 32'(fail), 32'h0);
    chk("rst_lockout", 32'(lockout), 32'h0);
    reset = 1'b1;
    press(4'h4);
    chk("idle_key_ignored", 32'(digit_count), 32'h0);

    // 1: correct code
    @(negedge clk);
    enable = 1'b1;
    press4(4'h4, 4'h6, 4'h9, 4'h3);
    chk("t1_entry", 32'(entry), 32'h4693);
    chk("t1_count", 32'(digit_count), 32'h4);
    press(4'hF);
    chk("t1_check_cycle_match", 32'(match), 32'h0);
    @(negedge clk);
    chk("t1_match", 32'(match), 32'h1);
    chk("t1_fail", 32'(fail), 32'h0);
    chk("t1_buf_cleared", 32'(entry), 32'h0);
    @(negedge clk);
    chk("t1_match_one_pulse", 32'(match), 32'h0);

    // 2: wrong code
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hF);
    @(negedge clk);
    chk("t2_fail", 32'(fail), 32'h1);
    chk("t2_lockout", 32'(lockout), 32'h0);
    chk("t2_entry", 32'(entry), 32'h0);
    @(negedge clk);
    chk("t2_fail_one_pulse", 32'(fail), 32'h0);

    // 3: match clears the counter, then two wrong entries lock out
    press4(4'h4, 4'h6, 4'h9, 4'h3);
    press(4'hF);
    @(negedge clk);
    chk("t3_match", 32'(match), 32'h1);
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hF);
    @(negedge clk);
    chk("t3_fail1", 32'(fail), 32'h1);
    chk("t3_no_lock_yet", 32'(lockout), 32'h0);
    press(4'hA);
    chk("t3_ignored_code", 32'(digit_count), 32'h0);
    press(4'h4);
    press(4'h6);
    press(4'h9);
    press(4'hF);
    @(negedge clk);
    chk("t3_short_fail", 32'(fail), 32'h1);
    chk("t3_lock_with_fail", 32'(lockout), 32'h1);
    @(negedge clk);
    chk("t3_fail_drop", 32'(fail), 32'h0);
    chk("t3_lock_held", 32'(lockout), 32'h1);
    press4(4'h4, 4'h6, 4'h9, 4'h3);
    chk("t3_locked_keys", 32'(digit_count), 32'h0);
    press(4'hF);
    @(negedge clk);
    chk("t3_locked_no_match", 32'(match), 32'h0);
    chk("t3_locked_still", 32'(lockout), 32'h1);
    @(negedge clk);
    clear_lock = 1'b1;
    @(negedge clk);
    clear_lock = 1'b0;
    chk("t3_unlock", 32'(lockout), 32'h0);

    // 4: clear mid-entry and 5th digit ignored
    press(4'h4);
    press(4'h6);
    press(4'hE);
    chk("t4_cleared", 32'(digit_count), 32'h0);
    press4(4'h4, 4'h6, 4'h9, 4'h3);
    press(4'h5);
    chk("t4_fifth_count", 32'(digit_count), 32'h4);
    chk("t4_fifth_entry", 32'(entry), 32'h4693);
    press(4'hF);
    @(negedge clk);
    chk("t4_match", 32'(match), 32'h1);

    // 5: inactivity timeout
    press(4'h4);
    press(4'h6);
    chk("t5_count2", 32'(digit_count), 32'h2);
    fail_seen = 1'b0;
    repeat (99) begin
      @(negedge clk);
      fail_seen = fail_seen | fail;
    end
    chk("t5_before_timeout", 32'(digit_count), 32'h2);
    @(negedge clk);
    fail_seen = fail_seen | fail;
    chk("t5_timeout_count", 32'(digit_count), 32'h0);
    chk("t5_timeout_entry", 32'(entry), 32'h0);
    chk("t5_no_fail", 32'(fail_seen), 32'h0);
    press4(4'h4, 4'h6, 4'h9, 4'h3);
    press(4'hF);
    @(negedge clk);
    chk("t5_match", 32'(match), 32'h1);

    // 6: abort coincident with a key, then async reset mid-entry
    press(4'h4);
    press(4'h6);
    @(negedge clk);
    enable    = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h9;
    @(negedge clk);
    key_valid = 1'b0;
    chk("t6_abort_count", 32'(digit_count), 32'h0);
    chk("t6_abort_entry", 32'(entry), 32'h0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    press(4'h4);
    press(4'h6);
    chk("t6_pre_reset", 32'(digit_count), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_count", 32'(digit_count), 32'h0);
    chk("t6_rst_entry", 32'(entry), 32'h0);
    chk("t6_rst_match", 32'(match), 32'h0);
    chk("t6_rst_fail", 32'(fail), 32'h0);
    chk("t6_rst_lockout", 32'(lockout), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
